tree_walker: RTL and testbench
==============================

Name: tree_walker

Overview:
- Sequencer directly upstream of the comparator stage in the SADDC decision-tree datapath.
- For each accepted classification command, walks a complete binary tree of depth DEPTH from the root.
- At each node: fetches the node's feature index and threshold from node memory, fetches that feature from feature memory, and issues one compare request to the comparator.
- Consumes the comparator's decision to pick the next node. Reports the reached leaf index with the command tag.

Parameters:
- DEPTH, 4, tree levels; internal nodes 0..2^DEPTH-2; leaves 0..2^DEPTH-1.
- NODE_AW, 4, node memory address width; must be >= DEPTH.
- FIDX_W, 8, feature index width.
- DATA_W, 32, feature and threshold width, two's complement.
- TAG_W, 8, command tag width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both valid and ready are high.
- cmd_tag  in  TAG_W  tag echoed with the result.
- node_rd_en  out  1  node memory read strobe.
- node_addr  out  NODE_AW  node index.
- node_feat_idx  in  FIDX_W  node memory data; valid the cycle after node_rd_en.
- node_thresh  in  DATA_W  node memory data; valid the cycle after node_rd_en.
- feat_rd_en  out  1  feature memory read strobe.
- feat_addr  out  FIDX_W  feature index.
- feat_rdata  in  DATA_W  feature value; valid the cycle after feat_rd_en.
- cmp_req_valid  out  1  compare request valid.
- cmp_req_ready  in  1  compare request ready.
- cmp_req_feature  out  DATA_W  feature operand.
- cmp_req_weights  out  DATA_W  threshold operand.
- cmp_resp_valid  in  1  compare response valid.
- cmp_resp_ready  out  1  compare response ready.
- cmp_resp_decision  in  1  1 = feature <= threshold (signed).
- leaf_valid  out  1  result valid.
- leaf_ready  in  1  result accepted.
- leaf_index  out  DEPTH  reached leaf.
- leaf_tag  out  TAG_W  tag of the command.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; all outputs 0 except cmd_ready=1.
  - Internal node_idx, level, captured threshold and feature, and tag are all 0.
  - An in-flight walk is abandoned; no leaf is produced for it.
- States and transitions:
  - IDLE: cmd_ready=1. On cmd fire, latch tag, node_idx=0, level=0 -> NODE_RD.
  - NODE_RD: node_rd_en=1, node_addr=node_idx -> NODE_WAIT.
  - NODE_WAIT: capture node_feat_idx and node_thresh -> FEAT_RD.
  - FEAT_RD: feat_rd_en=1, feat_addr=captured index -> FEAT_WAIT.
  - FEAT_WAIT: capture feat_rdata -> CMP_REQ.
  - CMP_REQ: cmp_req_valid=1. Operands are the captured registers and stay stable until fire.
    - cmp_resp_ready = cmp_req_ready, because the comparator may respond in the fire cycle.
    - Fire with resp_valid in the same cycle: consume the decision now.
    - Fire without resp_valid: -> CMP_RESP.
  - CMP_RESP: cmp_resp_ready=1; wait for cmp_resp_valid.
  - On decision consumed: next = 2*node_idx+1 when decision=1 (left), 2*node_idx+2 when decision=0 (right).
    - If level==DEPTH-1: leaf_index = next-(2^DEPTH-1), truncated to DEPTH bits -> DONE.
    - Otherwise node_idx=next, level+1 -> NODE_RD.
  - DONE: leaf_valid=1; leaf_index and leaf_tag stable until leaf_ready. On fire -> IDLE.
- Decision polarity: 1 means go left.
- Registered outputs: cmd_ready, strobes, addresses, cmp_req_valid, leaf_valid.
- Combinational exception: cmp_resp_ready in CMP_REQ.
- Ignored inputs:
  - cmp_resp_valid while cmp_resp_ready=0.
  - cmd_valid outside IDLE.
- Single walk in flight; no command queueing.
- Latency with an always-ready, same-cycle comparator:
  - 5 cycles per level.
  - cmd fire at cycle T -> leaf_valid first high at T+1+5*DEPTH (T+21 for DEPTH=4).
- Back-to-back: leaf fire and the next cmd fire are at least one cycle apart (DONE then IDLE).
- Backpressure: each extra cycle cmp_req_ready, cmp_resp_valid or leaf_ready is held off adds exactly one cycle.

Test Plan:
- All thresholds 0x7FFFFFFF, features 0x00000005, tag 0x3C:
  - -> node_addr sequence 0,1,3,7; leaf_index=0; leaf_tag=0x3C; leaf_valid at T+21.
- All thresholds 0x80000000, features 0:
  - -> node_addr sequence 0,2,6,14; leaf_index=15.
- Signed compare with feature 0xFFFFFFFF (-1) vs threshold 0 at root, other nodes forcing right:
  - -> first step left; node_addr 0,1,4,10; leaf_index=7.
- cmp_req_ready low 3 cycles at level 1, cmp_resp_valid delayed 2 cycles at level 2, leaf_ready low 4 cycles:
  - -> same leaf as the unstalled run; operands stable while stalled; leaf_valid 5 cycles later, then held 4 extra cycles.
- reset pulsed low during FEAT_WAIT of level 2:
  - -> all outputs 0 immediately and cmd_ready=1; the next command walks from node 0 correctly.
- Two commands offered back-to-back:
  - -> second accepted only after the first leaf fire; results in order with correct tags.

Source files
------------

// File: rtl/tree_walker.sv
// Decision-tree walker: for each command, walks a complete binary tree from the root,
// issuing one compare per level, then reports the reached leaf with the command's tag.
module tree_walker #(
    parameter int DEPTH   = 4,
    parameter int NODE_AW = 4,
    parameter int FIDX_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 8
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [TAG_W-1:0]   cmd_tag,

    output logic               node_rd_en,
    output logic [NODE_AW-1:0] node_addr,
    input  logic [FIDX_W-1:0]  node_feat_idx,
    input  logic [DATA_W-1:0]  node_thresh,

    output logic               feat_rd_en,
    output logic [FIDX_W-1:0]  feat_addr,
    input  logic [DATA_W-1:0]  feat_rdata,

    output logic               cmp_req_valid,
    input  logic               cmp_req_ready,
    output logic [DATA_W-1:0]  cmp_req_feature,
    output logic [DATA_W-1:0]  cmp_req_weights,
    input  logic               cmp_resp_valid,
    output logic               cmp_resp_ready,
    input  logic               cmp_resp_decision,

    output logic               leaf_valid,
    input  logic               leaf_ready,
    output logic [DEPTH-1:0]   leaf_index,
    output logic [TAG_W-1:0]   leaf_tag
);

    localparam int               LVL_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               NXT_W     = NODE_AW + 1;
    localparam logic [LVL_W-1:0] LAST_LVL  = LVL_W'(DEPTH - 1);
    localparam logic [DEPTH-1:0] LEAF_BASE = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NODE_RD,
        S_NODE_WAIT,
        S_FEAT_RD,
        S_FEAT_WAIT,
        S_CMP_REQ,
        S_CMP_RESP,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [NODE_AW-1:0] node_idx_q;
    logic [LVL_W-1:0]   level_q;
    logic [FIDX_W-1:0]  fidx_q;
    logic [DATA_W-1:0]  thresh_q;
    logic [DATA_W-1:0]  feat_q;
    logic [TAG_W-1:0]   tag_q;
    logic [DEPTH-1:0]   leaf_index_q;
    logic               cmd_ready_q;
    logic               node_rd_en_q;
    logic               feat_rd_en_q;
    logic               cmp_req_valid_q;
    logic               leaf_valid_q;

    logic [NODE_AW-1:0] next_idx_d;
    logic [DEPTH-1:0]   leaf_idx_d;
    logic               resp_fire;

    // Children of node n are 2n+1 (decision=1, left) and 2n+2 (right). Leaves are numbered
    // from 2^DEPTH-1, so only the low DEPTH bits of the child index matter for the leaf.
    always_comb begin
        next_idx_d = NODE_AW'({node_idx_q, 1'b0} + (cmp_resp_decision ? NXT_W'(1) : NXT_W'(2)));
        leaf_idx_d = next_idx_d[DEPTH-1:0] - LEAF_BASE;
    end

    // The comparator may answer in the same cycle it takes the request, so response
    // readiness follows request readiness while the request is still pending.
    assign cmp_resp_ready = (state_q == S_CMP_REQ) ? cmp_req_ready : (state_q == S_CMP_RESP);
    assign resp_fire      = cmp_resp_valid && cmp_resp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            node_idx_q      <= '0;
            level_q         <= '0;
            fidx_q          <= '0;
            thresh_q        <= '0;
            feat_q          <= '0;
            tag_q           <= '0;
            leaf_index_q    <= '0;
            cmd_ready_q     <= 1'b1;
            node_rd_en_q    <= 1'b0;
            feat_rd_en_q    <= 1'b0;
            cmp_req_valid_q <= 1'b0;
            leaf_valid_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        tag_q        <= cmd_tag;
                        node_idx_q   <= '0;
                        level_q      <= '0;
                        cmd_ready_q  <= 1'b0;
                        node_rd_en_q <= 1'b1;
                        state_q      <= S_NODE_RD;
                    end
                end
                S_NODE_RD: begin
                    node_rd_en_q <= 1'b0;
                    state_q      <= S_NODE_WAIT;
                end
                S_NODE_WAIT: begin
                    fidx_q       <= node_feat_idx;
                    thresh_q     <= node_thresh;
                    feat_rd_en_q <= 1'b1;
                    state_q      <= S_FEAT_RD;
                end
                S_FEAT_RD: begin
                    feat_rd_en_q <= 1'b0;
                    state_q      <= S_FEAT_WAIT;
                end
                S_FEAT_WAIT: begin
                    feat_q          <= feat_rdata;
                    cmp_req_valid_q <= 1'b1;
                    state_q         <= S_CMP_REQ;
                end
                S_CMP_REQ: begin
                    if (cmp_req_ready) begin
                        cmp_req_valid_q <= 1'b0;
                        state_q         <= S_CMP_RESP;
                    end
                end
                S_CMP_RESP: begin
                    state_q <= S_CMP_RESP;
                end
                S_DONE: begin
                    if (leaf_ready) begin
                        leaf_valid_q <= 1'b0;
                        cmd_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // NOTE: non-blocking updates resolve last-write-wins, so this overrides the
            // S_CMP_RESP move above when the decision arrives in the request's fire cycle.
            if (resp_fire) begin
                if (level_q == LAST_LVL) begin
                    leaf_index_q <= leaf_idx_d;
                    leaf_valid_q <= 1'b1;
                    state_q      <= S_DONE;
                end else begin
                    node_idx_q   <= next_idx_d;
                    level_q      <= level_q + LVL_W'(1);
                    node_rd_en_q <= 1'b1;
                    state_q      <= S_NODE_RD;
                end
            end
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign node_rd_en      = node_rd_en_q;
    assign node_addr       = node_idx_q;
    assign feat_rd_en      = feat_rd_en_q;
    assign feat_addr       = fidx_q;
    assign cmp_req_valid   = cmp_req_valid_q;
    assign cmp_req_feature = feat_q;
    assign cmp_req_weights = thresh_q;
    assign leaf_valid      = leaf_valid_q;
    assign leaf_index      = leaf_index_q;
    assign leaf_tag        = tag_q;

endmodule

// File: tb/tb_tree_walker.sv
// Directed bench for tree_walker: memory and comparator models around the DUT,
// hand-computed paths, leaves, tags and latencies checked with immediate assertions.
module tb_tree_walker;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_tag;
    logic        node_rd_en;
    logic [3:0]  node_addr;
    logic [7:0]  node_feat_idx;
    logic [31:0] node_thresh;
    logic        feat_rd_en;
    logic [7:0]  feat_addr;
    logic [31:0] feat_rdata;
    logic        cmp_req_valid;
    logic        cmp_req_ready;
    logic [31:0] cmp_req_feature;
    logic [31:0] cmp_req_weights;
    logic        cmp_resp_valid;
    logic        cmp_resp_ready;
    logic        cmp_resp_decision;
    logic        leaf_valid;
    logic        leaf_ready;
    logic [3:0]  leaf_index;
    logic [7:0]  leaf_tag;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  nfidx [16];
    logic [31:0] nthr  [16];
    logic [31:0] fmem  [256];
    logic [3:0]  addr_log [$];
    logic [7:0]  feat_log [$];
    logic [3:0]  cur_node = '0;
    int          req_stall  [4];
    int          resp_delay [4];
    int          req_num = 0;

    tree_walker #(
        .DEPTH(4), .NODE_AW(4), .FIDX_W(8), .DATA_W(32), .TAG_W(8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_tag           (cmd_tag),
        .node_rd_en        (node_rd_en),
        .node_addr         (node_addr),
        .node_feat_idx     (node_feat_idx),
        .node_thresh       (node_thresh),
        .feat_rd_en        (feat_rd_en),
        .feat_addr         (feat_addr),
        .feat_rdata        (feat_rdata),
        .cmp_req_valid     (cmp_req_valid),
        .cmp_req_ready     (cmp_req_ready),
        .cmp_req_feature   (cmp_req_feature),
        .cmp_req_weights   (cmp_req_weights),
        .cmp_resp_valid    (cmp_resp_valid),
        .cmp_resp_ready    (cmp_resp_ready),
        .cmp_resp_decision (cmp_resp_decision),
        .leaf_valid        (leaf_valid),
        .leaf_ready        (leaf_ready),
        .leaf_index        (leaf_index),
        .leaf_tag          (leaf_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory model: data for a strobe seen in one cycle appears from the next negedge,
    // i.e. valid for the capture edge that ends the following cycle; garbage otherwise.
    initial begin
        logic       nrd_p;
        logic       frd_p;
        logic [3:0] na_p;
        logic [7:0] fa_p;
        nrd_p = 1'b0; frd_p = 1'b0; na_p = '0; fa_p = '0;
        node_feat_idx = '0; node_thresh = '0; feat_rdata = '0;
        forever begin
            @(negedge clk);
            node_feat_idx = nrd_p ? nfidx[na_p] : 8'hA5;
            node_thresh   = nrd_p ? nthr[na_p]  : 32'hDEAD_BEEF;
            feat_rdata    = frd_p ? fmem[fa_p]  : 32'h5A5A_5A5A;
            nrd_p = node_rd_en; na_p = node_addr;
            frd_p = feat_rd_en; fa_p = feat_addr;
            if (node_rd_en) begin
                addr_log.push_back(node_addr);
                cur_node = node_addr;
            end
            if (feat_rd_en) feat_log.push_back(feat_addr);
        end
    end

    // Comparator model: optional request stall (offering a wrong, unready response meanwhile)
    // and optional response delay, indexed by request number within the walk.
    initial begin
        int          k;
        logic [31:0] ef;
        logic [31:0] et;
        logic        dec;
        cmp_req_ready = 1'b0; cmp_resp_valid = 1'b0; cmp_resp_decision = 1'b0;
        forever begin
            @(negedge clk);
            cmp_req_ready = 1'b0; cmp_resp_valid = 1'b0; cmp_resp_decision = 1'b0;
            if (cmp_req_valid) begin
                k = (req_num < 4) ? req_num : 3;
                req_num++;
                ef  = fmem[nfidx[cur_node]];
                et  = nthr[cur_node];
                dec = ($signed(ef) <= $signed(et));
                check("req_feature", cmp_req_feature, ef);
                check("req_weights", cmp_req_weights, et);
                for (int s = 0; s < req_stall[k]; s++) begin
                    cmp_resp_valid = 1'b1;
                    cmp_resp_decision = ~dec;
                    @(negedge clk);
                    cmp_resp_valid = 1'b0;
                    check("stall_req_valid", cmp_req_valid, 1'b1);
                    check("stall_feature", cmp_req_feature, ef);
                    check("stall_weights", cmp_req_weights, et);
                end
                cmp_req_ready = 1'b1;
                if (resp_delay[k] == 0) begin
                    cmp_resp_valid = 1'b1;
                    cmp_resp_decision = dec;
                end else begin
                    @(negedge clk);
                    cmp_req_ready = 1'b0;
                    repeat (resp_delay[k] - 1) @(negedge clk);
                    cmp_resp_valid = 1'b1;
                    cmp_resp_decision = dec;
                end
            end
        end
    end

    task automatic set_cfg(input logic [31:0] thr_root, input logic [31:0] thr_rest,
                           input logic [31:0] feat_root, input logic [31:0] feat_rest);
        for (int i = 0; i < 16; i++) begin
            nfidx[i] = 8'(i * 16 + 7);
            nthr[i]  = (i == 0) ? thr_root : thr_rest;
        end
        for (int i = 0; i < 256; i++) fmem[i] = feat_rest;
        fmem[nfidx[0]] = feat_root;
    endtask

    task automatic check_rst_outputs(input string name);
        check({name, ":cmd_ready"},  cmd_ready,       1'b1);
        check({name, ":node_rd_en"}, node_rd_en,      1'b0);
        check({name, ":node_addr"},  node_addr,       4'h0);
        check({name, ":feat_rd_en"}, feat_rd_en,      1'b0);
        check({name, ":feat_addr"},  feat_addr,       8'h0);
        check({name, ":req_valid"},  cmp_req_valid,   1'b0);
        check({name, ":req_feat"},   cmp_req_feature, 32'h0);
        check({name, ":req_wts"},    cmp_req_weights, 32'h0);
        check({name, ":resp_ready"}, cmp_resp_ready,  1'b0);
        check({name, ":leaf_valid"}, leaf_valid,      1'b0);
        check({name, ":leaf_index"}, leaf_index,      4'h0);
        check({name, ":leaf_tag"},   leaf_tag,        8'h0);
    endtask

    task automatic walk(input string name, input logic [7:0] tag, input int hold,
                        input logic [3:0] exp_leaf, input int exp_lat,
                        input logic [3:0] a0, input logic [3:0] a1,
                        input logic [3:0] a2, input logic [3:0] a3);
        logic [3:0] ea [4];
        int         lat;
        ea[0] = a0; ea[1] = a1; ea[2] = a2; ea[3] = a3;
        addr_log.delete(); feat_log.delete(); req_num = 0;
        @(negedge clk);
        check({name, ":idle_ready"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_tag = tag;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                cmd_valid = 1'b0; cmd_tag = 8'h00;
                check({name, ":busy_ready"}, cmd_ready, 1'b0);
                check({name, ":first_rd"}, {node_rd_en, node_addr}, {1'b1, 4'h0});
            end
            if (leaf_valid) break;
        end
        check({name, ":latency"},    lat,        exp_lat);
        check({name, ":leaf_index"}, leaf_index, exp_leaf);
        check({name, ":leaf_tag"},   leaf_tag,   tag);
        repeat (hold) begin
            @(negedge clk);
            check({name, ":hold_valid"}, leaf_valid, 1'b1);
            check({name, ":hold_index"}, leaf_index, exp_leaf);
        end
        leaf_ready = 1'b1;
        @(negedge clk);
        leaf_ready = 1'b0;
        check({name, ":leaf_drop"}, leaf_valid, 1'b0);
        check({name, ":back_idle"}, cmd_ready,  1'b1);
        check({name, ":n_node_rd"}, addr_log.size(), 4);
        check({name, ":n_feat_rd"}, feat_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s:node_addr%0d", name, i), addr_log[i], ea[i]);
            check($sformatf("%s:feat_addr%0d", name, i), feat_log[i], nfidx[ea[i]]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat;
        logic seen;
        cmd_valid = 1'b0; cmd_tag = 8'h00; leaf_ready = 1'b0; reset = 1'b0;
        for (int i = 0; i < 4; i++) begin req_stall[i] = 0; resp_delay[i] = 0; end
        set_cfg(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h0000_0005);

        repeat (3) @(negedge clk);
        check_rst_outputs("in_reset");
        reset = 1'b1;
        @(negedge clk);
        check_rst_outputs("after_reset");

        // Everything below threshold: always left.
        walk("all_left", 8'h3C, 0, 4'd0, 21, 4'd0, 4'd1, 4'd3, 4'd7);

        // Threshold at most-negative value: always right.
        set_cfg(32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0);
        walk("all_right", 8'hC3, 0, 4'd15, 21, 4'd0, 4'd2, 4'd6, 4'd14);

        // -1 <= 0 signed at the root goes left, then right everywhere.
        set_cfg(32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        walk("signed", 8'h81, 0, 4'd7, 21, 4'd0, 4'd1, 4'd4, 4'd10);

        // Same tree with request stall at level 1, response delay at level 2, leaf held off.
        req_stall[1] = 3; resp_delay[2] = 2;
        walk("stalled", 8'h42, 4, 4'd7, 26, 4'd0, 4'd1, 4'd4, 4'd10);
        req_stall[1] = 0; resp_delay[2] = 0;

        // Reset during level-2 FEAT_WAIT abandons the walk.
        set_cfg(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h0000_0005);
        addr_log.delete(); feat_log.delete(); req_num = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_tag = 8'h77;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) cmd_valid = 1'b0;
        end
        check("pre_reset:feat_reads", feat_log.size(), 3);
        check("pre_reset:req_valid", cmp_req_valid, 1'b0);
        reset = 1'b0;
        #1;
        check_rst_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            seen = seen | leaf_valid | node_rd_en | cmp_req_valid;
        end
        check("abandoned_walk_quiet", seen, 1'b0);
        walk("post_reset", 8'h5A, 0, 4'd0, 21, 4'd0, 4'd1, 4'd3, 4'd7);

        // Two commands offered back to back with cmd_valid held high throughout.
        set_cfg(32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0);
        addr_log.delete(); feat_log.delete(); req_num = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_tag = 8'h11;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) cmd_tag = 8'h22;
            if (leaf_valid) break;
            if (lat == 10) check("b2b:held_off", cmd_ready, 1'b0);
        end
        check("b2b:first_latency", lat, 21);
        check("b2b:first_leaf", leaf_index, 4'd15);
        check("b2b:first_tag", leaf_tag, 8'h11);
        leaf_ready = 1'b1;
        @(negedge clk);
        leaf_ready = 1'b0;
        req_num = 0;
        check("b2b:gap_idle", {cmd_ready, leaf_valid}, 2'b10);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                cmd_valid = 1'b0;
                check("b2b:second_taken", cmd_ready, 1'b0);
            end
            if (leaf_valid) break;
        end
        check("b2b:second_latency", lat, 21);
        check("b2b:second_leaf", leaf_index, 4'd15);
        check("b2b:second_tag", leaf_tag, 8'h22);
        leaf_ready = 1'b1;
        @(negedge clk);
        leaf_ready = 1'b0;
        check("b2b:done", {cmd_ready, leaf_valid}, 2'b10);
        check("b2b:node_reads", addr_log.size(), 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
